// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial pattern transmitter with repeat count and abort
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [REP_W-1:0] rep_in,
  input  logic             abort,
  output logic             ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
  localparam logic [REP_W-1:0] ONE_R   = REP_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_eff;
  logic [WIDTH-1:0] aligned;

  // Left-align the active field so the next bit to send is always the MSB.
  always_comb begin
    len_eff = ((len_in == '0) || (len_in > WIDTH_L)) ? WIDTH_L : len_in;
    aligned = data_in << (WIDTH_L - len_eff);
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    shift_d   = shift_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    x_out_d   = 1'b0;
    x_valid_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (load && !abort) begin
          pat_d     = aligned;
          shift_d   = aligned << 1;
          len_d     = len_eff;
          idx_d     = len_eff - ONE_L;
          rep_d     = rep_in;
          x_out_d   = aligned[WIDTH-1];
          x_valid_d = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          shift_d = '0;
          idx_d   = '0;
          rep_d   = '0;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          if (rep_q != '0) begin
            rep_d     = rep_q - ONE_R;
            idx_d     = len_q - ONE_L;
            shift_d   = pat_q << 1;
            x_out_d   = pat_q[WIDTH-1];
            x_valid_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          idx_d     = idx_q - ONE_L;
          shift_d   = shift_q << 1;
          x_out_d   = shift_q[WIDTH-1];
          x_valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      shift_q   <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign done    = done_q;

endmodule
